// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: memory-wait, branch-flush and load-use stall decode.
// Optional perf counters (stall_cnt, flush_cnt) are enabled by defining HAZ_PERF_CNT_EN.
module hazard_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_use_rs1,
    input  logic       id_use_rs2,
    input  logic       ex_memR,
    input  logic [4:0] ex_rd,
    input  logic       ex_branch_taken,
    input  logic       mem_access,
    input  logic       dmem_ready,
    output logic       pc_write,
    output logic       ifid_write,
    output logic       idex_write,
    output logic       exmem_write,
    output logic       ifid_flush,
    output logic       flush_hd,
    output logic [1:0] state_o,
    output logic       mem_timeout
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
`endif
);

    typedef enum logic [1:0] {
        StRun     = 2'b00,
        StMemWait = 2'b01
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       mem_timeout_q;

    logic mem_stall;
    logic load_use;
    logic branch_flush;

    // Unused encodings never stall here; they fall back to StRun on the next edge.
    assign mem_stall = (state_q == StMemWait) ||
                       ((state_q == StRun) && mem_access && !dmem_ready);

    assign load_use = ex_memR && (ex_rd != 5'd0) &&
                      ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                       (id_use_rs2 && (id_rs2 == ex_rd)));

    assign branch_flush = !mem_stall && ex_branch_taken;

    always_comb begin
        state_d = StRun;
        case (state_q)
            StRun:     state_d = (mem_access && !dmem_ready) ? StMemWait : StRun;
            StMemWait: state_d = dmem_ready ? StRun : StMemWait;
            default:   state_d = StRun;
        endcase
    end

    always_comb begin
        wait_cnt_d = 8'd0;
        if (state_q == StMemWait) begin
            wait_cnt_d = (wait_cnt_q == 8'hff) ? wait_cnt_q : wait_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= StRun;
            wait_cnt_q    <= 8'd0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            if ((state_q == StMemWait) && (wait_cnt_q == 8'hff)) begin
                mem_timeout_q <= 1'b1;
            end
        end
    end

    // Priority: memory wait, then branch flush, then load-use bubble.
    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        idex_write  = 1'b1;
        exmem_write = 1'b1;
        ifid_flush  = 1'b0;
        flush_hd    = 1'b0;
        if (mem_stall) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_write  = 1'b0;
            exmem_write = 1'b0;
        end else if (ex_branch_taken) begin
            ifid_flush = 1'b1;
            flush_hd   = 1'b1;
        end else if (load_use) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            flush_hd   = 1'b1;
        end
    end

    assign state_o     = state_q;
    assign mem_timeout = mem_timeout_q;

`ifdef HAZ_PERF_CNT_EN
    logic [31:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            if (!pc_write) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (branch_flush) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    logic unused_branch_flush;
    assign unused_branch_flush = branch_flush;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model of the hazard rules.
module tb_hazard_ctrl;

    logic       clk;
    logic       rst;
    logic [4:0] id_rs1, id_rs2;
    logic       id_use_rs1, id_use_rs2;
    logic       ex_memR;
    logic [4:0] ex_rd;
    logic       ex_branch_taken;
    logic       mem_access, dmem_ready;
    logic       pc_write, ifid_write, idex_write, exmem_write;
    logic       ifid_flush, flush_hd;
    logic [1:0] state_o;
    logic       mem_timeout;
`ifdef HAZ_PERF_CNT_EN
    logic [31:0] stall_cnt, flush_cnt;
`endif

    hazard_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_use_rs1      (id_use_rs1),
        .id_use_rs2      (id_use_rs2),
        .ex_memR         (ex_memR),
        .ex_rd           (ex_rd),
        .ex_branch_taken (ex_branch_taken),
        .mem_access      (mem_access),
        .dmem_ready      (dmem_ready),
        .pc_write        (pc_write),
        .ifid_write      (ifid_write),
        .idex_write      (idex_write),
        .exmem_write     (exmem_write),
        .ifid_flush      (ifid_flush),
        .flush_hd        (flush_hd),
        .state_o         (state_o),
        .mem_timeout     (mem_timeout)
`ifdef HAZ_PERF_CNT_EN
        ,
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // Model state: whether a memory wait is in progress and how many edges it has lasted.
    bit          m_wait;
    int          m_cycles;
    bit          m_timeout;
    logic [31:0] m_stall;
    logic [31:0] m_flush;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_wait    = 1'b0;
        m_cycles  = 0;
        m_timeout = 1'b0;
        m_stall   = 32'd0;
        m_flush   = 32'd0;
    endtask

    function automatic bit exp_mem_stall();
        return m_wait || (mem_access && !dmem_ready);
    endfunction

    function automatic bit exp_load_use();
        if (!ex_memR || ex_rd == 5'd0) return 1'b0;
        return (id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd);
    endfunction

    // {pc_write, ifid_write, idex_write, exmem_write, ifid_flush, flush_hd}
    function automatic logic [5:0] exp_outs();
        if (exp_mem_stall())  return 6'b0000_00;
        if (ex_branch_taken)  return 6'b1111_11;
        if (exp_load_use())   return 6'b0011_01;
        return 6'b1111_00;
    endfunction

    task automatic run_cycle(input string tag);
        logic [5:0] ev;
        #1;
        ev = exp_outs();
        check_eq({tag, ".outs"}, {26'd0, pc_write, ifid_write, idex_write, exmem_write,
                                  ifid_flush, flush_hd}, {26'd0, ev});
        check_eq({tag, ".state"}, {30'd0, state_o}, m_wait ? 32'd1 : 32'd0);
        check_eq({tag, ".tmo"}, {31'd0, mem_timeout}, {31'd0, m_timeout});
`ifdef HAZ_PERF_CNT_EN
        check_eq({tag, ".stall_cnt"}, stall_cnt, m_stall);
        check_eq({tag, ".flush_cnt"}, flush_cnt, m_flush);
`endif
        @(posedge clk);
        if (!rst) begin
            model_reset();
        end else begin
            if (!ev[5]) m_stall = m_stall + 32'd1;
            if (!exp_mem_stall() && ex_branch_taken) m_flush = m_flush + 32'd1;
            if (m_wait) begin
                if (m_cycles >= 255) m_timeout = 1'b1;
                m_cycles++;
                if (dmem_ready) begin
                    m_wait   = 1'b0;
                    m_cycles = 0;
                end
            end else if (mem_access && !dmem_ready) begin
                m_wait   = 1'b1;
                m_cycles = 0;
            end
        end
        @(negedge clk);
    endtask

    task automatic set_idle();
        id_rs1          = 5'd0;
        id_rs2          = 5'd0;
        id_use_rs1      = 1'b0;
        id_use_rs2      = 1'b0;
        ex_memR         = 1'b0;
        ex_rd           = 5'd0;
        ex_branch_taken = 1'b0;
        mem_access      = 1'b0;
        dmem_ready      = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        set_idle();
        model_reset();
        @(negedge clk);
        run_cycle("reset");
        mem_access = 1'b1;
        dmem_ready = 1'b0;
        run_cycle("reset_decode");
        set_idle();
        rst = 1'b1;
        run_cycle("post_reset");

        // Load-use on rs2, then released.
        ex_memR = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_use_rs2 = 1'b1;
        run_cycle("load_use");
        ex_memR = 1'b0;
        run_cycle("load_use_next");

        // x0 destination never stalls.
        set_idle();
        ex_memR = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_use_rs1 = 1'b1;
        run_cycle("x0_filter");

        // Branch beats load-use.
        set_idle();
        ex_memR = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd7; id_use_rs1 = 1'b1;
        ex_branch_taken = 1'b1;
        run_cycle("branch_lu");
        set_idle();
        run_cycle("idle");

        // Memory wait of three cycles, with branch and load-use masked underneath.
        mem_access = 1'b1; dmem_ready = 1'b0; ex_branch_taken = 1'b1;
        for (int i = 0; i < 3; i++) run_cycle("mem_wait");
        dmem_ready = 1'b1;
        run_cycle("mem_wait_done");
        set_idle();
        run_cycle("mem_wait_after");
        check_eq("mem_wait_run", {30'd0, state_o}, 32'd0);

        // Timeout: 300 cycles without ready.
        mem_access = 1'b1; dmem_ready = 1'b0;
        for (int i = 0; i < 300; i++) run_cycle("timeout");
        check_eq("timeout_set", {31'd0, mem_timeout}, 32'd1);
        dmem_ready = 1'b1;
        run_cycle("timeout_release");
        set_idle();
        for (int i = 0; i < 3; i++) run_cycle("timeout_sticky");
        check_eq("timeout_held", {31'd0, mem_timeout}, 32'd1);

        // Reset mid-wait aborts immediately.
        mem_access = 1'b1; dmem_ready = 1'b0;
        for (int i = 0; i < 4; i++) run_cycle("pre_abort");
        rst = 1'b0;
        model_reset();
        #1;
        check_eq("abort_state", {30'd0, state_o}, 32'd0);
        check_eq("abort_tmo", {31'd0, mem_timeout}, 32'd0);
        set_idle();
        run_cycle("abort_reset");
        rst = 1'b1;
        run_cycle("abort_after");

        // Randomized traffic with small register indices so hazards occur often.
        for (int i = 0; i < 800; i++) begin
            id_rs1          = 5'($urandom_range(0, 3));
            id_rs2          = 5'($urandom_range(0, 3));
            id_use_rs1      = 1'($urandom_range(0, 1));
            id_use_rs2      = 1'($urandom_range(0, 1));
            ex_memR         = 1'($urandom_range(0, 1));
            ex_rd           = 5'($urandom_range(0, 3));
            ex_branch_taken = ($urandom_range(0, 4) == 0);
            mem_access      = ($urandom_range(0, 3) == 0);
            dmem_ready      = ($urandom_range(0, 9) < 6);
            run_cycle("random");
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
